alu_issue_arbiter: RTL and testbench

Sequences and shares one registered ALU function unit (64-bit logic/arith units with registered outputs) between two requesters: port 0, the EX-stage issue path, and port 1, a secondary requester such as a multi-cycle helper. It grants one request at a time using round-robin, holds operands stable for the unit's fixed latency, captures the result, and returns it with a requester tag over a valid/ready response channel. It sits in the ALU wrapper between the EX-stage control and the registered function units.

---
 rtl/alu_issue_arbiter.sv | 101 ++++++++++
 tb/tb_alu_issue_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters; handshake to rsp_valid is LAT+2 cycles.
// Requests are only accepted when idle or while the pending response retires; rsp_valid holds until rsp_ready.
module alu_issue_arbiter #(
  parameter int W   = 64,
  parameter int OPW = 3,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  input  logic           rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       last;
  logic       id;
  logic [2:0] cnt;
  logic       can_accept;
  logic       grant1;
  logic       handshake;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    grant1     = req1_valid && (!req0_valid || !last);
  end

  assign req0_ready = !rst && can_accept && req0_valid && !grant1;
  assign req1_ready = !rst && can_accept && grant1;
  assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      id        <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      if (handshake) begin
        alu_op <= grant1 ? req1_op : req0_op;
        alu_a  <= grant1 ? req1_a  : req0_a;
        alu_b  <= grant1 ? req1_b  : req0_b;
        id     <= grant1;
        last   <= grant1;
        cnt    <= 3'(LAT);
        state  <= EXEC;
      end
      case (state)
        IDLE: begin
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            rsp_data  <= alu_result;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          // A handshake in this cycle already moved us to EXEC above.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!handshake) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench: LAT=1 instance under directed and random traffic, plus a LAT=3 instance for latency/stability.
module tb_alu_issue_arbiter;
  localparam int W = 64;
  localparam int OPW = 3;
  localparam int LAT0 = 1;

  typedef struct packed {
    logic        id;
    logic [63:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LAT=1 instance
  logic           rst, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic           rsp_valid, rsp_id, rsp_ready;

  // LAT=3 instance
  logic           s_rst, s_req0_valid, s_req1_valid, s_req0_ready, s_req1_ready;
  logic [OPW-1:0] s_req0_op, s_req1_op, s_alu_op;
  logic [W-1:0]   s_req0_a, s_req0_b, s_req1_a, s_req1_b, s_alu_a, s_alu_b, s_alu_result, s_rsp_data;
  logic           s_rsp_valid, s_rsp_id, s_rsp_ready;

  alu_issue_arbiter #(.W(W), .OPW(OPW), .LAT(LAT0)) u0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  alu_issue_arbiter #(.W(W), .OPW(OPW), .LAT(3)) u1 (
    .clk(clk), .rst(s_rst),
    .req0_valid(s_req0_valid), .req0_op(s_req0_op), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_ready(s_req0_ready),
    .req1_valid(s_req1_valid), .req1_op(s_req1_op), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_ready(s_req1_ready),
    .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .rsp_ready(s_rsp_ready)
  );

  function automatic logic [63:0] alu_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[5:0];
      3'd6: return a >> b[5:0];
      default: return ~a;
    endcase
  endfunction

  // Behavioural function units: result appears LAT clocks after the operands.
  logic [63:0] p3 [3];
  always @(posedge clk) begin
    alu_result <= alu_f(alu_op, alu_a, alu_b);
    p3[0] <= alu_f(s_alu_op, s_alu_a, s_alu_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign s_alu_result = p3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a response is due LAT+2 cycles after its issue; new work
  // is taken when nothing is outstanding or the due response retires now.
  rsp_t sb [$];
  bit   m_out = 1'b0;
  int   m_due = 0;
  bit   m_last = 1'b1;
  bit   m_ev, m_can, m_g0, m_g1, m_e0, m_e1;
  always @(negedge clk) begin
    m_ev  = m_out && (cyc >= m_due);
    m_can = !m_out || (m_ev && rsp_ready);
    m_g1  = req1_valid && (!req0_valid || !m_last);
    m_g0  = req0_valid && !m_g1;
    m_e0  = !rst && m_can && m_g0;
    m_e1  = !rst && m_can && m_g1;
    chk("req0_ready", 64'(req0_ready), 64'(m_e0));
    chk("req1_ready", 64'(req1_ready), 64'(m_e1));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_ev));
    if (rst) begin
      m_out  = 1'b0;
      m_last = 1'b1;
      sb.delete();
    end else begin
      if (m_ev && rsp_ready) m_out = 1'b0;
      if (m_e0 || m_e1) begin
        m_out  = 1'b1;
        m_due  = cyc + LAT0 + 2;
        m_last = m_e1;
        sb.push_back(rsp_t'{id: m_e1, data: m_e1 ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b)});
      end
    end
  end

  // Monitor: compares each retired response and checks stability while stalled.
  bit          held = 1'b0;
  logic [63:0] h_data;
  logic        h_id;
  rsp_t        mon_e;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (held) begin
        chk("hold_data", rsp_data, h_data);
        chk("hold_id", 64'(rsp_id), 64'(h_id));
      end
      if (rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id %0d data %h, expected no response", rsp_id, rsp_data);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          chk("rsp_data", rsp_data, mon_e.data);
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        h_data = rsp_data;
        h_id   = rsp_id;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
  endtask

  task automatic send0(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        step();
        req0_valid = 1'b0;
        return;
      end
      step();
    end
    total++; bad++;
    $display("FAIL send0_timeout: got no req0_ready, expected one within 20 cycles");
    req0_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
      step();
    end
    total++; bad++;
    $display("FAIL rsp_timeout: got no rsp_valid, expected one within 20 cycles");
  endtask

  int  gid [$];
  int  gcy [$];
  bit  h0, h1, found;
  int  n;
  logic [63:0] a3, b3;
  localparam logic [63:0] T1A = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] T1B = 64'h0F0F_0F0F_0F0F_0F0F;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    s_rst = 1'b1; s_rsp_ready = 1'b1;
    s_req0_valid = 0; s_req0_op = '0; s_req0_a = '0; s_req0_b = '0;
    s_req1_valid = 0; s_req1_op = '0; s_req1_a = '0; s_req1_b = '0;
    // Requests presented during reset must not be taken.
    req0_valid = 1'b1; req1_valid = 1'b1;
    step(); step();
    @(negedge clk);
    chk_reset("reset");
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single AND op
    step();
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = T1A; req0_b = T1B;
    @(negedge clk); chk("t1_ready0", 64'(req0_ready), 64'd1);
    step(); req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_alu_a", alu_a, T1A); chk("t1_alu_b", alu_b, T1B); chk("t1_alu_op", 64'(alu_op), 64'd2);
    step(); step();
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_data", rsp_data, 64'h0F0F_0000_0F0F_0000);
    chk("t1_rsp_id", 64'(rsp_id), 64'd0);
    repeat (3) step();

    // Contention from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req0_op = 3'($urandom); req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
    req1_valid = 1'b1; req1_op = 3'($urandom); req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
    repeat (12) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0) begin gid.push_back(0); gcy.push_back(cyc); end
      if (h1) begin gid.push_back(1); gcy.push_back(cyc); end
      step();
      if (h0) begin req0_op = 3'($urandom); req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; end
      if (h1) begin req1_op = 3'($urandom); req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_grants", 64'(gid.size()), 64'd4);
    for (int i = 0; i < 4 && i < gid.size(); i++) begin
      chk("cont_order", 64'(gid[i]), 64'(i % 2));
      if (i > 0) chk("cont_spacing", 64'(gcy[i] - gcy[i-1]), 64'd3);
    end
    repeat (4) step();

    // Backpressure
    rsp_ready = 1'b0;
    send0(3'd4, 64'h1234_5678_9ABC_DEF0, 64'h0FF0_0FF0_0FF0_0FF0);
    wait_rsp();
    req1_op = 3'd1; req1_a = 64'd1000; req1_b = 64'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      req1_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid_held", 64'(rsp_valid), 64'd1);
      chk("bp_ready1_low", 64'(req1_ready), 64'd0);
      chk("bp_ready0_low", 64'(req0_ready), 64'd0);
    end
    step(); rsp_ready = 1'b1;
    @(negedge clk); chk("bp_ready1_same_cycle", 64'(req1_ready), 64'd1);
    step(); req1_valid = 1'b0;
    @(negedge clk); chk("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    repeat (4) step();

    // Reset mid-EXEC
    send0(3'd0, 64'd5, 64'd6);
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_exec");
    chk("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (6) step();
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 64'hF0; req0_b = 64'h0F;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 64'd9; req1_b = 64'd9;
    @(negedge clk);
    chk("tie_after_rst_p0", 64'(req0_ready), 64'd1);
    chk("tie_after_rst_p1", 64'(req1_ready), 64'd0);
    step(); req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = req1_ready;
      step();
    end
    req1_valid = 1'b0;
    chk("tie_p1_served", 64'(found), 64'd1);
    repeat (6) step();

    // Randomized traffic with occasional withdrawals, backpressure and resets
    repeat (3000) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      step();
      rst = ($urandom_range(0, 399) == 0);
      if (h0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 3'($urandom); req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (h1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 3'($urandom); req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // LAT=3 instance: latency, operand stability, withdrawn request
    s_rst = 1'b0;
    step();
    @(negedge clk); chk("lat3_reset_alu_a", s_alu_a, 64'd0);
    step();
    a3 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
    s_req0_valid = 1'b1; s_req0_op = 3'd0; s_req0_a = a3; s_req0_b = b3;
    @(negedge clk); chk("lat3_ready", 64'(s_req0_ready), 64'd1);
    found = 1'b0; n = 0;
    while (!found && n < 12) begin
      step(); n++;
      s_req0_valid = (n == 2);
      s_req0_a = {$urandom, $urandom};
      @(negedge clk);
      if (n == 2) chk("lat3_withdraw_no_grant", 64'(s_req0_ready), 64'd0);
      chk("lat3_alu_a_stable", s_alu_a, a3);
      found = s_rsp_valid;
    end
    chk("lat3_latency", 64'(n), 64'd5);
    chk("lat3_rsp_data", s_rsp_data, a3 + b3);
    chk("lat3_rsp_id", 64'(s_rsp_id), 64'd0);
    step(); s_req0_valid = 1'b0;
    @(negedge clk);
    chk("lat3_rsp_retired", 64'(s_rsp_valid), 64'd0);
    chk("lat3_idle_no_ready", 64'(s_req0_ready), 64'd0);
    step(); step();
    @(negedge clk);
    chk("lat3_no_extra_rsp", 64'(s_rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
